// File: rtl/kwin_line_buffer.sv
// kwin_line_buffer: 3x3 raster window generator with two line buffers and a registered, back-pressured window output.
// Optional KWIN_SOF_EN adds a sof input that restarts the frame at the accepted pixel.
module kwin_line_buffer #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pix_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] p1,
    output logic [7:0] p2,
    output logic [7:0] p3,
    output logic [7:0] p4,
    output logic [7:0] p5,
    output logic [7:0] p6,
    output logic [7:0] p7,
    output logic [7:0] p8,
    output logic [7:0] p9,
    output logic       win_valid,
    input  logic       win_ready
`ifdef KWIN_SOF_EN
    ,
    input  logic       sof
`endif
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    logic [CW-1:0] col, ccol;
    logic [RW-1:0] row, crow;
    logic [7:0]    lb0 [IMG_W];
    logic [7:0]    lb1 [IMG_W];
    logic [7:0]    t0, t1, m0, m1, b0, b1, top, mid;
    logic          acc, emit, last_col, last_row;
    always_comb begin
        in_ready = !win_valid || win_ready;
        acc      = in_valid && in_ready;
`ifdef KWIN_SOF_EN
        ccol     = sof ? '0 : col;
        crow     = sof ? '0 : row;
`else
        ccol     = col;
        crow     = row;
`endif
        top      = lb1[ccol];
        mid      = lb0[ccol];
        emit     = acc && crow >= RW'(2) && ccol >= CW'(2);
        last_col = ccol == CW'(IMG_W - 1);
        last_row = crow == RW'(IMG_H - 1);
    end
    // lb0 holds row-1, lb1 holds row-2; contents survive reset and frame wrap
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[ccol] <= mid;
            lb0[ccol] <= pix_in;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
            win_valid <= 1'b0;
            {t0, t1, m0, m1, b0, b1} <= '0;
            {p1, p2, p3, p4, p5, p6, p7, p8, p9} <= '0;
        end else begin
            if (acc) begin
                {t0, t1} <= {t1, top};
                {m0, m1} <= {m1, mid};
                {b0, b1} <= {b1, pix_in};
                col <= last_col ? '0 : ccol + CW'(1);
                row <= last_col ? (last_row ? '0 : crow + RW'(1)) : crow;
            end
            if (emit) begin
                {p1, p2, p3, p4, p5, p6, p7, p8, p9} <= {t0, t1, top, m0, m1, mid, b0, b1, pix_in};
                win_valid <= 1'b1;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_kwin_line_buffer.sv
// tb_kwin_line_buffer: scoreboard bench for kwin_line_buffer at IMG_W=5, IMG_H=4.
// Build with KWIN_SOF_EN defined to also exercise frame resynchronisation.
module tb_kwin_line_buffer;
    localparam int W = 5;
    localparam int H = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] pix_in = '0;
    logic in_valid = 1'b0;
    logic win_ready = 1'b1;
    logic in_ready, win_valid;
    logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
`ifdef KWIN_SOF_EN
    logic sof = 1'b0;
`endif
    int checks = 0;
    int errors = 0;
    int nwin = 0;
    int mr = 0;
    int mc = 0;
    logic mvalid = 1'b0;
    logic [7:0] fr [H][W];
    logic [71:0] q[$];
    logic [71:0] win;
    localparam logic [71:0] FIRST = {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12};
    localparam logic [71:0] SECOND = {8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13};
    localparam logic [71:0] LAST = {8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19};

    assign win = {p1, p2, p3, p4, p5, p6, p7, p8, p9};

    kwin_line_buffer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .in_valid(in_valid), .in_ready(in_ready),
        .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8), .p9(p9),
        .win_valid(win_valid), .win_ready(win_ready)
`ifdef KWIN_SOF_EN
        , .sof(sof)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mr = 0;
        mc = 0;
        mvalid = 1'b0;
        nwin = 0;
        q.delete();
    endtask

    task automatic step(input logic v, input logic [7:0] px, input logic wr, input logic s, output logic took);
        logic [71:0] e;
        @(negedge clk);
        in_valid = v;
        pix_in = px;
        win_ready = wr;
`ifdef KWIN_SOF_EN
        sof = s;
`endif
        #1;
        took = v && (!mvalid || wr);
        checks++;
        if (win_valid !== mvalid) begin
            errors++;
            $display("FAIL win_valid: got %b expected %b at %0t", win_valid, mvalid, $time);
        end
        checks++;
        if (in_ready !== (!mvalid || wr)) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b at %0t", in_ready, !mvalid || wr, $time);
        end
        if (mvalid && wr) begin
            e = (q.size() > 0) ? q.pop_front() : 'x;
            checks++;
            if (win !== e) begin
                errors++;
                $display("FAIL window: got %h expected %h at %0t", win, e, $time);
            end
            mvalid = 1'b0;
            nwin++;
        end
        if (took) begin
`ifdef KWIN_SOF_EN
            if (s) begin
                mr = 0;
                mc = 0;
            end
`endif
            fr[mr][mc] = px;
            if (mr >= 2 && mc >= 2) begin
                q.push_back({fr[mr-2][mc-2], fr[mr-2][mc-1], fr[mr-2][mc],
                             fr[mr-1][mc-2], fr[mr-1][mc-1], fr[mr-1][mc],
                             fr[mr][mc-2], fr[mr][mc-1], fr[mr][mc]});
                mvalid = 1'b1;
            end
            mc = (mc == W - 1) ? 0 : mc + 1;
            if (mc == 0) mr = (mr == H - 1) ? 0 : mr + 1;
        end
    endtask

    task automatic send(input logic [7:0] px, input logic rnd, input logic s);
        logic took = 1'b0;
        for (int i = 0; i < 40 && !took; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) step(1'b0, 8'hee, 1'b1, 1'b0, took);
            step(1'b1, px, rnd ? 1'($urandom_range(0, 1)) : 1'b1, s, took);
        end
        checks++;
        if (!took) begin
            errors++;
            $display("FAIL accept_timeout: pixel %0d got not-accepted expected accepted", px);
        end
    endtask

    task automatic drain();
        logic took;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, took);
    endtask

    task automatic check_win(input string name, input logic [71:0] e);
        @(posedge clk);
        #2;
        checks++;
        if ({win_valid, win} !== {1'b1, e}) begin
            errors++;
            $display("FAIL %s: got valid=%b win=%h expected valid=1 win=%h", name, win_valid, win, e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({win_valid, win, in_ready} !== {1'b0, 72'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got valid=%b win=%h in_ready=%b expected 0/0/1", win_valid, win, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({win_valid, win} !== 73'h0) begin
            errors++;
            $display("FAIL reset_initial: got valid=%b win=%h expected 0/0", win_valid, win);
        end
        do_reset();
    endtask

    task automatic test_stream();
        for (int k = 0; k < 13; k++) send(8'(k), 1'b0, 1'b0);
        check_win("first_window", FIRST);
        for (int k = 13; k < 20; k++) send(8'(k), 1'b0, 1'b0);
        check_win("last_window", LAST);
        for (int k = 0; k < 20; k++) send(8'(k), 1'b0, 1'b0);
        check_win("frame2_last_window", LAST);
        drain();
        checks++;
        if (nwin != 12) begin
            errors++;
            $display("FAIL window_count: got %0d expected 12", nwin);
        end
    endtask

    task automatic test_backpressure();
        logic took;
        do_reset();
        for (int k = 0; k < 13; k++) send(8'(k), 1'b0, 1'b0);
        check_win("bp_first", FIRST);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'd13, 1'b0, 1'b0, took);
            checks++;
            if ({win_valid, win, took} !== {1'b1, FIRST, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold: got valid=%b win=%h took=%b expected 1/%h/0", win_valid, win, took, FIRST);
            end
        end
        send(8'd13, 1'b0, 1'b0);
        check_win("bp_resume", SECOND);
        for (int k = 14; k < 20; k++) send(8'(k), 1'b0, 1'b0);
        drain();
        checks++;
        if (nwin != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d expected 6", nwin);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 9; k++) send(8'(k), 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({win_valid, win} !== 73'h0) begin
            errors++;
            $display("FAIL mid_reset_async: got valid=%b win=%h expected 0/0", win_valid, win);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (win_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_hold: got valid=%b expected 0", win_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 13; k++) send(8'(k), 1'b0, 1'b0);
        check_win("mid_reset_first", FIRST);
        drain();
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 20; k++) send(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        drain();
        checks++;
        if (nwin != 18 || q.size() != 0) begin
            errors++;
            $display("FAIL random_count: got %0d windows, %0d pending expected 18, 0", nwin, q.size());
        end
    endtask

`ifdef KWIN_SOF_EN
    task automatic test_sof();
        do_reset();
        for (int k = 0; k < 7; k++) send(8'(k), 1'b0, 1'b0);
        send(8'd7, 1'b0, 1'b1);
        for (int k = 8; k < 20; k++) send(8'(k), 1'b0, 1'b0);
        check_win("sof_first", LAST);
        drain();
        checks++;
        if (nwin != 1) begin
            errors++;
            $display("FAIL sof_count: got %0d expected 1", nwin);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef KWIN_SOF_EN
        test_sof();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/kwin_line_buffer.md
KWIN_LINE_BUFFER -- requirements
Module: kwin_line_buffer

Interface
REQ-001 SHALL have parameter IMG_W, default 16, meaning pixels per image row (legal range 3..1024).
REQ-002 SHALL have parameter IMG_H, default 16, meaning rows per frame (legal range 3..1024).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port pix_in, input, 8 bits: raster-order pixel, row-major, top-left first.
REQ-006 SHALL have port in_valid, input, 1 bit: pix_in is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts pix_in this cycle.
REQ-008 SHALL have ports p1..p9, output, 8 bits each: 3x3 window for the Kirsch kernel stages; p1 p2 p3 top row, p4 p5 p6 middle row, p7 p8 p9 bottom row, left to right.
REQ-009 SHALL have port win_valid, output, 1 bit: p1..p9 hold a valid window.
REQ-010 SHALL have port win_ready, input, 1 bit: downstream consumes the window this cycle.
REQ-011 SHALL have port sof, input, 1 bit, present only when KWIN_SOF_EN is defined: start of frame, qualified by in_valid.

Function
REQ-012 SHALL accept a pixel when in_valid && in_ready; in_ready = !win_valid || win_ready (combinational).
REQ-013 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), advanced once per accepted pixel; col wraps to 0 and increments row at IMG_W-1; both wrap to 0 after pixel (IMG_H-1, IMG_W-1).
REQ-014 SHALL store the two previous rows in two IMG_W-deep line buffers, written at address col on each accepted pixel.
REQ-015 SHALL keep three 3-tap column shift registers (one per window row), shifted only on an accepted pixel.
REQ-016 SHALL, on an accepted pixel at (row, col) with row >= 2 and col >= 2, register a window centred on (row-1, col-1) with p9 = that pixel, and assert win_valid on the next cycle (latency 1).
REQ-017 SHALL NOT emit a window for pixels in rows 0..1 or columns 0..1; windows per frame = (IMG_H-2)*(IMG_W-2).
REQ-018 SHALL hold p1..p9 and win_valid stable while win_valid && !win_ready.
REQ-019 SHALL deassert win_valid after win_valid && win_ready unless a new window is registered in the same cycle.
REQ-020 SHALL never straddle a row boundary: windows at col >= 2 use only pixels from the current three rows.
REQ-021 SHALL NOT clear line buffer contents at frame wrap; rows 0..1 of each frame are never emitted, so stale data is never output.

Reset
REQ-022 SHALL, while rst_n = 0, clear col, row, win_valid and p1..p9 to 0 immediately, regardless of clk.
REQ-023 SHALL, after mid-frame reset, treat the next accepted pixel as (0,0) of a new frame.
REQ-024 Line buffer contents SHALL be don't-care after reset.

Configuration
REQ-025 Macro KWIN_SOF_EN SHALL control frame resynchronisation.
REQ-026 With KWIN_SOF_EN defined: accepted pixel with sof = 1 SHALL be taken as (0,0); counters then continue from (0,1); any pending output window still completes its handshake.
REQ-027 Without KWIN_SOF_EN: no sof port; frame alignment only by reset and counter wrap.

Verification (IMG_W = 5, IMG_H = 4, pixel k = value k, 0..19)
REQ-028 Continuous stream, win_ready = 1 -> first win_valid one cycle after pixel 12: p1..p9 = 0,1,2,5,6,7,10,11,12.
REQ-029 Same stream -> exactly 6 windows per frame; last window p1..p9 = 7,8,9,12,13,14,17,18,19; second frame identical.
REQ-030 win_ready = 0 for 3 cycles on first window -> window held, in_ready = 0, no pixel lost; resumes with window p9 = 13.
REQ-031 rst_n low after pixel 8, then restart stream 0..19 -> win_valid = 0 during reset; outputs identical to REQ-028.
REQ-032 KWIN_SOF_EN defined, sof with pixel 7 of a running frame -> pixel 7 becomes (0,0); first window appears after 12 further pixels.
